// File: rtl/p2_position_integrator.sv
// Player-2 X position integrator.
// Accumulates knockback displacement and walk steps into a registered X
// position, keeps it inside the right arena wall and clear of player 1,
// and runs a short stun window once a knockback finishes.
module p2_position_integrator #(
    parameter int signed X_MIN       = 0,
    parameter int signed X_MAX       = 638,
    parameter int signed SPRITE_W    = 125,
    parameter int signed X_START     = 400,
    parameter int signed WALK_STEP   = 2,
    parameter int        STUN_FRAMES = 6,
    parameter int signed MIN_GAP     = 10
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               frame_tick,
    input  logic               move_left,
    input  logic               move_right,
    input  logic signed [31:0] knock_motion,
    input  logic signed [31:0] opp_right_edge,
    output logic signed [31:0] Xpos,
    output logic               at_right_wall,
    output logic               stunned,
    output logic               knocked
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WALK      = 2'd1,
        KNOCKBACK = 2'd2,
        STUN      = 2'd3
    } state_t;

    localparam int CW = (STUN_FRAMES < 2) ? 1 : $clog2(STUN_FRAMES + 1);
    localparam logic [CW-1:0]      STUN_LOAD = CW'(STUN_FRAMES);
    // Rightmost legal position, held at 33 bits so sums can be compared
    // against it without wrapping.
    localparam logic signed [32:0] R_LIM33   = 33'(X_MAX - SPRITE_W);
    localparam logic signed [31:0] R_LIM     = 32'(X_MAX - SPRITE_W);
    localparam logic signed [31:0] X_MIN_L   = 32'(X_MIN);
    localparam logic signed [31:0] GAP_L     = 32'(MIN_GAP);
    localparam logic signed [32:0] STEP33    = 33'(WALK_STEP);
    localparam logic signed [31:0] STEP32    = 32'(WALK_STEP);
    localparam logic signed [31:0] START_L   = 32'(X_START);

    state_t               state_q, state_d;
    logic signed [31:0]   xpos_q, xpos_d;
    logic [CW-1:0]        stun_cnt_q, stun_cnt_d;
    logic                 wall_q, wall_d;
    logic                 stunned_q, stunned_d;
    logic                 knocked_q, knocked_d;

    logic signed [31:0]   opp_lim;
    logic signed [31:0]   left_lim;
    logic signed [32:0]   knock_sum;
    logic signed [32:0]   walk_r_sum;
    logic signed [31:0]   walk_l_pos;
    logic                 knock_active;

    // Clamp limits and candidate positions for this frame.
    always_comb begin
        opp_lim      = opp_right_edge + GAP_L;
        left_lim     = (opp_lim > X_MIN_L) ? opp_lim : X_MIN_L;
        knock_sum    = {xpos_q[31], xpos_q} + {knock_motion[31], knock_motion};
        walk_r_sum   = {xpos_q[31], xpos_q} + STEP33;
        walk_l_pos   = xpos_q - STEP32;
        knock_active = (knock_motion > 32'sd0);
    end

    // Next-state, next-position and next-flag logic; knockback overrides all.
    always_comb begin
        state_d    = state_q;
        xpos_d     = xpos_q;
        stun_cnt_d = stun_cnt_q;

        if (knock_active) begin
            xpos_d     = (knock_sum > R_LIM33) ? R_LIM : knock_sum[31:0];
            state_d    = KNOCKBACK;
            stun_cnt_d = '0;
        end else begin
            case (state_q)
                KNOCKBACK: begin
                    stun_cnt_d = STUN_LOAD;
                    state_d    = STUN;
                end
                STUN: begin
                    stun_cnt_d = stun_cnt_q - 1'b1;
                    if (stun_cnt_d == '0) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    if (move_right && !move_left) begin
                        xpos_d  = (walk_r_sum > R_LIM33) ? R_LIM : walk_r_sum[31:0];
                        state_d = WALK;
                    end else if (move_left && !move_right) begin
                        // Player 1 already overlapping the gap: stand still
                        // rather than being pushed right.
                        if (xpos_q >= left_lim) begin
                            xpos_d = (walk_l_pos > left_lim) ? walk_l_pos : left_lim;
                        end
                        state_d = WALK;
                    end else begin
                        state_d = IDLE;
                    end
                end
            endcase
        end

        wall_d    = (xpos_d == R_LIM);
        stunned_d = (state_d == STUN);
        knocked_d = (state_d == KNOCKBACK);
    end

    // State register; advances only on frame ticks, reset wins.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            xpos_q     <= START_L;
            stun_cnt_q <= '0;
            wall_q     <= 1'b0;
            stunned_q  <= 1'b0;
            knocked_q  <= 1'b0;
        end else if (frame_tick) begin
            state_q    <= state_d;
            xpos_q     <= xpos_d;
            stun_cnt_q <= stun_cnt_d;
            wall_q     <= wall_d;
            stunned_q  <= stunned_d;
            knocked_q  <= knocked_d;
        end
    end

    assign Xpos          = xpos_q;
    assign at_right_wall = wall_q;
    assign stunned       = stunned_q;
    assign knocked       = knocked_q;

endmodule
